// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch, the
// load/store port and the boot loader, one access per cycle.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  input  logic              ld_mode,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              cpu_hold,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             fetch_first;

  // State, starvation counter and read-return flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      f_rvalid <= f_gnt;
      d_rvalid <= d_gnt & ~d_we;
    end
  end

  assign fetch_first = (wait_cnt == CNT_W'(MAX_WAIT));

  // Arbitration, RAM drive and next state
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    f_gnt        = 1'b0;
    d_gnt        = 1'b0;
    ld_gnt       = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    case (state)
      RUN: begin
        if (ld_mode) begin
          state_nxt = DRAIN;
        end else begin
          if (f_req && (fetch_first || !d_req)) begin
            f_gnt    = 1'b1;
            ram_en   = 1'b1;
            ram_addr = f_addr;
          end else if (d_req) begin
            d_gnt     = 1'b1;
            ram_en    = 1'b1;
            ram_we    = d_we;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
          end
          // A denied fetch at MAX_WAIT is impossible, so no overflow guard
          if (f_req && !f_gnt) begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        state_nxt = ld_mode ? LOAD : RUN;
      end
      LOAD: begin
        if (ld_wr) begin
          ld_gnt    = 1'b1;
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = ld_addr;
          ram_wdata = ld_wdata;
        end
        if (!ld_mode) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign cpu_hold = (state != RUN);
  // The RAM output register holds the read data; expose it only with a valid
  assign rdata    = (f_rvalid || d_rvalid) ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, cycle-level reference model,
// directed scenarios followed by randomized traffic.
module tb_ram_port_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req, f_gnt, f_rvalid;
  logic [AW-1:0] f_addr;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          ld_mode, ld_wr, ld_gnt, cpu_hold;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic [DW-1:0] rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .ld_mode(ld_mode), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .cpu_hold(cpu_hold), .rdata(rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Synchronous single-port RAM seen by the DUT
  logic [DW-1:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Reference model state: mode 0=running, 1=draining, 2=loading
  int            mode;
  int            denied;
  bit            pend_f, pend_d;
  logic [DW-1:0] pend_val;
  logic [DW-1:0] ref_mem [256];

  int checks = 0;
  int errors = 0;

  logic          o_fgnt, o_dgnt, o_lgnt, o_frv, o_drv, o_hold, o_en, o_we;
  logic [DW-1:0] o_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs at the falling edge, then advance the model
  task automatic step();
    bit ef, ed, el, ren, rwe;
    logic [AW-1:0] ra;
    logic [DW-1:0] rw;
    @(negedge clk);
    ef = 0; ed = 0; el = 0; ren = 0; rwe = 0; ra = '0; rw = '0;
    if (mode == 0 && !ld_mode) begin
      if (f_req && (denied >= MW || !d_req)) begin
        ef = 1; ren = 1; ra = f_addr;
      end else if (d_req) begin
        ed = 1; ren = 1; rwe = d_we; ra = d_addr; rw = d_wdata;
      end
    end else if (mode == 2 && ld_wr) begin
      el = 1; ren = 1; rwe = 1; ra = ld_addr; rw = ld_wdata;
    end
    check("grants", 32'({f_gnt, d_gnt, ld_gnt}), 32'({ef, ed, el}));
    check("rvalid", 32'({f_rvalid, d_rvalid}), 32'({pend_f, pend_d}));
    check("rdata", 32'(rdata), (pend_f || pend_d) ? 32'(pend_val) : 32'(0));
    check("cpu_hold", 32'(cpu_hold), 32'(mode != 0));
    check("ram_ctl", 32'({ram_en, ram_we}), 32'({ren, rwe}));
    check("ram_addr", 32'(ram_addr), 32'(ra));
    check("ram_wdata", 32'(ram_wdata), 32'(rw));
    o_fgnt = f_gnt; o_dgnt = d_gnt; o_lgnt = ld_gnt; o_frv = f_rvalid;
    o_drv = d_rvalid; o_hold = cpu_hold; o_en = ram_en; o_we = ram_we;
    o_rdata = rdata;
    @(posedge clk);
    if (ren && !rwe) pend_val = ref_mem[ra];
    if (ren && rwe)  ref_mem[ra] = rw;
    if (reset) begin
      mode = 0; denied = 0; pend_f = 0; pend_d = 0;
    end else begin
      pend_f = ef;
      pend_d = ed && !rwe;
      if (mode == 0 && !ld_mode && f_req && !ef) denied = (denied < MW) ? denied + 1 : MW;
      else denied = 0;
      if (mode == 0)      mode = ld_mode ? 1 : 0;
      else if (mode == 1) mode = ld_mode ? 2 : 0;
      else                mode = ld_mode ? 2 : 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 0; d_req = 0; d_we = 0; ld_mode = 0; ld_wr = 0;
  endtask

  bit [5:0] fpat, dpat;
  int       nld, nwe;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = DW'(i * 7 + 3);
      ref_mem[i] = DW'(i * 7 + 3);
    end
    ram_mem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
    ram_mem[8'h20] = 8'h3C; ref_mem[8'h20] = 8'h3C;
    ram_rdata = '0;
    mode = 0; denied = 0; pend_f = 0; pend_d = 0; pend_val = '0;
    reset = 1;
    idle_inputs();
    f_addr = '0; d_addr = '0; d_wdata = '0; ld_addr = '0; ld_wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    step();

    // Reset lands on the cycle of a fetch grant: the read is dropped
    f_req = 1; f_addr = 8'h10; reset = 1;
    step();
    check("t1_gnt_in_reset_cycle", 32'(o_fgnt), 32'(1));
    f_req = 0; reset = 0;
    step();
    check("t1_outputs_after_reset",
          32'({o_fgnt, o_dgnt, o_lgnt, o_frv, o_drv, o_hold, o_en, o_we, o_rdata}), 32'(0));

    // Lone fetch
    f_req = 1; f_addr = 8'h10;
    step();
    check("t2_fgnt", 32'(o_fgnt), 32'(1));
    f_req = 0;
    step();
    check("t2_frvalid", 32'(o_frv), 32'(1));
    check("t2_rdata", 32'(o_rdata), 32'(8'hA5));

    // Both held: four data grants, then the starved fetch, then data again
    f_req = 1; f_addr = 8'h11; d_req = 1; d_we = 0; d_addr = 8'h20;
    for (int i = 0; i < 6; i++) begin
      step();
      fpat[i] = o_fgnt;
      dpat[i] = o_dgnt;
    end
    check("t3_fetch_pattern", 32'(fpat), 32'(6'b010000));
    check("t3_data_pattern", 32'(dpat), 32'(6'b101111));
    idle_inputs();
    step();

    // Store then fetch of the same address
    d_req = 1; d_we = 1; d_addr = 8'h30; d_wdata = 8'h5C;
    step();
    check("t4_store_gnt", 32'({o_dgnt, o_we}), 32'(2'b11));
    d_req = 0; d_we = 0; f_req = 1; f_addr = 8'h30;
    step();
    check("t4_no_store_rvalid", 32'(o_drv), 32'(0));
    f_req = 0;
    step();
    check("t4_fetch_data", 32'({o_frv, o_rdata}), 32'({1'b1, 8'h5C}));

    // Loader takes over right behind a load; the load's data still returns
    d_req = 1; d_we = 0; d_addr = 8'h20;
    step();
    d_req = 0; ld_mode = 1;
    step();
    check("t5_load_rvalid", 32'({o_drv, o_rdata}), 32'({1'b1, 8'h3C}));
    step();
    check("t5_drain_hold", 32'({o_hold, o_en}), 32'(2'b10));
    nld = 0; nwe = 0;
    for (int i = 0; i < 4; i++) begin
      ld_wr = 1; ld_addr = AW'(i); ld_wdata = DW'(8'hC0 + i);
      step();
      nld += int'(o_lgnt);
      nwe += int'(o_we);
    end
    check("t5_ld_gnt_count", 32'(nld), 32'(4));
    check("t5_ram_we_count", 32'(nwe), 32'(4));
    ld_wr = 0; ld_mode = 0;
    step();
    check("t5_hold_last_load_cycle", 32'(o_hold), 32'(1));
    step();
    check("t5_hold_released", 32'(o_hold), 32'(0));
    f_req = 1; f_addr = 8'h02;
    step();
    f_req = 0;
    step();
    check("t5_loaded_data", 32'(o_rdata), 32'(8'hC2));

    // Loader strobe outside LOAD is ignored
    ld_wr = 1; ld_addr = 8'h10; ld_wdata = 8'hFF;
    step();
    check("t6_ld_ignored", 32'({o_lgnt, o_we, o_en}), 32'(0));
    ld_wr = 0; f_req = 1; f_addr = 8'h10;
    step();
    f_req = 0;
    step();
    check("t6_mem_unchanged", 32'(o_rdata), 32'(8'hA5));

    // Randomized traffic; requesters hold until granted
    for (int n = 0; n < 600; n++) begin
      if (!f_req || o_fgnt) begin
        f_req  = ($urandom_range(0, 99) < 60);
        f_addr = AW'($urandom);
      end
      if (!d_req || o_dgnt) begin
        d_req   = ($urandom_range(0, 99) < 60);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = AW'($urandom);
        d_wdata = DW'($urandom);
      end
      if (ld_mode) ld_mode = ($urandom_range(0, 99) >= 15);
      else         ld_mode = ($urandom_range(0, 99) < 5);
      ld_wr    = $urandom_range(0, 1) == 1;
      ld_addr  = AW'($urandom);
      ld_wdata = DW'($urandom);
      reset    = ($urandom_range(0, 99) == 0);
      step();
      if (reset) begin
        o_fgnt = 1; o_dgnt = 1;
      end
    end
    reset = 0;
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
